acla_pipe_adder: RTL

- Parametrised, handshaked successor to the fixed 4/6/8-bit speculative-carry adder blocks.
- WIDTH-bit add is split into WIDTH/BLK blocks. Each block above block 0 takes a speculative carry-in, computed from the lower block's own operand bits only.
- Adds a per-transaction mode: approximate (fast, may be inexact) or accurate (error detected and corrected in one extra cycle).
- Sits between operand producer and result consumer via valid/ready handshakes.

---
 rtl/acla_pipe_adder_if.sv | 27 ++
 rtl/acla_pipe_adder.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/acla_pipe_adder_if.sv
// acla_pipe_adder_if: operand/result valid-ready bus for acla_pipe_adder.
// The master modport is for the testbench; the slave modport is for the adder.
interface acla_pipe_adder_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             err;
  logic [CNT_W-1:0] err_cnt;
  modport master (
    output in_valid, a, b, cin, mode, out_ready,
    input  in_ready, out_valid, sum, cout, err, err_cnt
  );
  modport slave (
    input  in_valid, a, b, cin, mode, out_ready,
    output in_ready, out_valid, sum, cout, err, err_cnt
  );
endinterface

// File: rtl/acla_pipe_adder.sv
// acla_pipe_adder: handshaked block-speculative adder with approximate/accurate modes.
// Define ACLA_ERR_CNT_EN to build the saturating speculation-error counter; otherwise err_cnt is tied to 0.
module acla_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  acla_pipe_adder_if.slave bus
);
  localparam int NB = WIDTH / BLK;
  if (WIDTH % BLK != 0 || BLK < 2) begin : g_bad_cfg
    $error("acla_pipe_adder: WIDTH must be a multiple of BLK and BLK must be >= 2");
  end
  typedef enum logic [1:0] {IDLE, EVAL, CORR, OUT} state_t;
  state_t           state_q, state_d;
  logic             ph_q, ph_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             cin_q, cin_d, mode_q, mode_d;
  logic [WIDTH-1:0] apx_sum_q, apx_sum_d, ex_sum_q, ex_sum_d;
  logic             apx_cout_q, apx_cout_d, ex_cout_q, ex_cout_d, mis_q, mis_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d, err_q, err_d;
  logic [NB-1:0]    c_spec, c_true;
  logic [WIDTH-1:0] spec_sum, exact_sum;
  logic             spec_cout, exact_cout, spec_err;
  assign c_spec[0] = cin_q;
  for (genvar k = 0; k < NB; k++) begin : g_blk
    logic [BLK:0] g_add;
    assign g_add = {1'b0, a_q[k*BLK +: BLK]} + {1'b0, b_q[k*BLK +: BLK]};
    assign spec_sum[k*BLK +: BLK] = g_add[BLK-1:0] + BLK'(c_spec[k]);
    assign c_true[k] = a_q[k*BLK] ^ b_q[k*BLK] ^ exact_sum[k*BLK];
    // a block's generate (carry-in forced to 0) becomes the next block's guess
    if (k == NB - 1) begin : g_top
      assign spec_cout = g_add[BLK] | (c_spec[k] & (&g_add[BLK-1:0]));
    end else begin : g_fwd
      assign c_spec[k+1] = g_add[BLK];
    end
  end
  assign {exact_cout, exact_sum} = {1'b0, a_q} + {1'b0, b_q} + (WIDTH+1)'(cin_q);
  assign spec_err = |(c_spec ^ c_true);
  always_comb begin
    state_d    = state_q;
    ph_d       = ph_q;
    a_d        = a_q;
    b_d        = b_q;
    cin_d      = cin_q;
    mode_d     = mode_q;
    apx_sum_d  = apx_sum_q;
    apx_cout_d = apx_cout_q;
    ex_sum_d   = ex_sum_q;
    ex_cout_d  = ex_cout_q;
    mis_d      = mis_q;
    sum_d      = sum_q;
    cout_d     = cout_q;
    err_d      = err_q;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        a_d     = bus.a;
        b_d     = bus.b;
        cin_d   = bus.cin;
        mode_d  = bus.mode;
        ph_d    = 1'b0;
        state_d = EVAL;
      end
      // first EVAL cycle registers both candidate results, second one picks
      EVAL: if (!ph_q) begin
        apx_sum_d  = spec_sum;
        apx_cout_d = spec_cout;
        ex_sum_d   = exact_sum;
        ex_cout_d  = exact_cout;
        mis_d      = spec_err;
        ph_d       = 1'b1;
      end else if (mis_q && mode_q) begin
        state_d = CORR;
      end else begin
        sum_d   = apx_sum_q;
        cout_d  = apx_cout_q;
        err_d   = mis_q;
        state_d = OUT;
      end
      CORR: begin
        sum_d   = ex_sum_q;
        cout_d  = ex_cout_q;
        err_d   = 1'b1;
        state_d = OUT;
      end
      OUT: state_d = bus.out_ready ? IDLE : OUT;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      ph_q       <= 1'b0;
      a_q        <= '0;
      b_q        <= '0;
      cin_q      <= 1'b0;
      mode_q     <= 1'b0;
      apx_sum_q  <= '0;
      apx_cout_q <= 1'b0;
      ex_sum_q   <= '0;
      ex_cout_q  <= 1'b0;
      mis_q      <= 1'b0;
      sum_q      <= '0;
      cout_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      ph_q       <= ph_d;
      a_q        <= a_d;
      b_q        <= b_d;
      cin_q      <= cin_d;
      mode_q     <= mode_d;
      apx_sum_q  <= apx_sum_d;
      apx_cout_q <= apx_cout_d;
      ex_sum_q   <= ex_sum_d;
      ex_cout_q  <= ex_cout_d;
      mis_q      <= mis_d;
      sum_q      <= sum_d;
      cout_q     <= cout_d;
      err_q      <= err_d;
    end
  end
  assign bus.in_ready  = state_q == IDLE;
  assign bus.out_valid = state_q == OUT;
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;
  assign bus.err       = err_q;
`ifdef ACLA_ERR_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             hit;
  assign hit = state_q != OUT && state_d == OUT && err_d;
  always_comb cnt_d = (hit && cnt_q != '1) ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end
  assign bus.err_cnt = cnt_q;
`else
  assign bus.err_cnt = '0;
`endif
endmodule
